// File: rtl/ber_pkg.sv
// Shared definitions for the BER measurement path: counter widths used by
// ber_meas_ctrl and ber_7seg, and the sequencer state encoding.
package ber_pkg;

    localparam int BW_RECV = 58;
    localparam int BW_ERR  = 64;
    localparam int BW_LOSS = 8;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_CLEAR  = 3'd1;
    localparam logic [2:0] ENC_COUNT  = 3'd2;
    localparam logic [2:0] ENC_SNAP   = 3'd3;
    localparam logic [2:0] ENC_RESYNC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_CLEAR  = ENC_CLEAR,
        ST_COUNT  = ENC_COUNT,
        ST_SNAP   = ENC_SNAP,
        ST_RESYNC = ENC_RESYNC
    } state_e;

endpackage

// File: rtl/ber_meas_ctrl_if.sv
// Bundle between the PRBS checker / operator controls and the measurement
// sequencer, plus the snapshot and status results going to the display.
interface ber_meas_ctrl_if;
    import ber_pkg::*;

    logic               RUN;
    logic               CLR;
    logic               LOCK;
    logic               BIT_VLD;
    logic               BIT_ERR;
    logic               START;
    logic [BW_RECV-1:0] RECV_CNT;
    logic [BW_ERR-1:0]  ERR_CNT;
    logic [BW_LOSS-1:0] LOSS_CNT;
    logic               SAT;
    logic               BUSY;

    modport master (
        output RUN, CLR, LOCK, BIT_VLD, BIT_ERR,
        input  START, RECV_CNT, ERR_CNT, LOSS_CNT, SAT, BUSY
    );

    modport slave (
        input  RUN, CLR, LOCK, BIT_VLD, BIT_ERR,
        output START, RECV_CNT, ERR_CNT, LOSS_CNT, SAT, BUSY
    );

endinterface

// File: rtl/ber_sat_cnt.sv
// Saturating up-counter: stops at all-ones instead of wrapping so a long run
// never reports a small, misleading total.
module ber_sat_cnt #(
    parameter int BW = 8
) (
    input  logic          CLK,
    input  logic          RSTX,
    input  logic          CLR,
    input  logic          INC,
    output logic [BW-1:0] Q,
    output logic          FULL
);

    logic [BW-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (INC && !(&q_q)) begin
            q_d = q_q + BW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign FULL = &q_q;

endmodule

// File: rtl/ber_meas_ctrl.sv
// Measurement sequencer: gates BER counting on RUN/LOCK and snapshots the
// cumulative totals once per INTERVAL so ber_7seg divides stable operands.
module ber_meas_ctrl
    import ber_pkg::*;
#(
    parameter int INTERVAL = 50_000_000,
    parameter int BW_TMR   = 26
) (
    input logic            CLK,
    input logic            RSTX,
    ber_meas_ctrl_if.slave bus
);

    localparam logic [BW_TMR-1:0] TMR_LAST = BW_TMR'(INTERVAL - 1);

    state_e             state_q, state_d;
    logic [BW_TMR-1:0]  tmr_q, tmr_d;
    logic [BW_RECV-1:0] snap_recv_q, snap_recv_d;
    logic [BW_ERR-1:0]  snap_err_q, snap_err_d;
    logic               start_q, start_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;

    logic [BW_RECV-1:0] recv_q, recv_nxt;
    logic [BW_ERR-1:0]  err_q, err_nxt;
    logic [BW_LOSS-1:0] loss_q;
    logic               recv_full, err_full, loss_full;
    logic               counting, in_clear, snap_go;
    logic               recv_inc, err_inc, loss_inc;

    assign counting = (state_q == ST_COUNT) || (state_q == ST_SNAP);
    assign in_clear = (state_q == ST_CLEAR);
    assign recv_inc = counting && bus.BIT_VLD && bus.LOCK;
    assign err_inc  = recv_inc && bus.BIT_ERR;
    assign snap_go  = (state_q == ST_COUNT) && (state_d == ST_SNAP);
    assign loss_inc = counting && (state_d == ST_RESYNC) && !loss_full;

    // Snapshot must include the bit of the terminal COUNT cycle, so it is
    // taken from the counters' next value rather than their current one.
    assign recv_nxt = (recv_inc && !recv_full) ? recv_q + BW_RECV'(1) : recv_q;
    assign err_nxt  = (err_inc && !err_full) ? err_q + BW_ERR'(1) : err_q;

    ber_sat_cnt #(.BW(BW_RECV)) u_recv (
        .CLK  (CLK),
        .RSTX (RSTX),
        .CLR  (in_clear),
        .INC  (recv_inc),
        .Q    (recv_q),
        .FULL (recv_full)
    );

    ber_sat_cnt #(.BW(BW_ERR)) u_err (
        .CLK  (CLK),
        .RSTX (RSTX),
        .CLR  (in_clear),
        .INC  (err_inc),
        .Q    (err_q),
        .FULL (err_full)
    );

    ber_sat_cnt #(.BW(BW_LOSS)) u_loss (
        .CLK  (CLK),
        .RSTX (RSTX),
        .CLR  (in_clear),
        .INC  (loss_inc),
        .Q    (loss_q),
        .FULL (loss_full)
    );

    // RUN dominates, then CLR (ignored while idle), then loss of lock.
    always_comb begin
        state_d = state_q;
        if (!bus.RUN) begin
            state_d = ST_IDLE;
        end else if (bus.CLR && (state_q != ST_IDLE)) begin
            state_d = ST_CLEAR;
        end else if (!bus.LOCK && counting) begin
            state_d = ST_RESYNC;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.LOCK) state_d = ST_CLEAR;
                ST_CLEAR:  state_d = ST_COUNT;
                ST_COUNT:  if (tmr_q >= TMR_LAST) state_d = ST_SNAP;
                ST_SNAP:   state_d = ST_COUNT;
                ST_RESYNC: if (bus.LOCK) state_d = ST_COUNT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_d       = tmr_q;
        snap_recv_d = snap_recv_q;
        snap_err_d  = snap_err_q;
        start_d     = 1'b0;
        sat_d       = sat_q | recv_full | err_full;
        busy_d      = (state_d != ST_IDLE);

        case (state_q)
            ST_CLEAR: tmr_d = '0;
            ST_COUNT: tmr_d = tmr_q + BW_TMR'(1);
            ST_SNAP:  tmr_d = BW_TMR'(1);
            default:  tmr_d = tmr_q;
        endcase

        if (in_clear) begin
            snap_recv_d = '0;
            snap_err_d  = '0;
            sat_d       = 1'b0;
        end else if (snap_go) begin
            snap_recv_d = recv_nxt;
            snap_err_d  = err_nxt;
            start_d     = (recv_nxt != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            snap_recv_q <= '0;
            snap_err_q  <= '0;
            start_q     <= 1'b0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            snap_recv_q <= snap_recv_d;
            snap_err_q  <= snap_err_d;
            start_q     <= start_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.START    = start_q;
    assign bus.RECV_CNT = snap_recv_q;
    assign bus.ERR_CNT  = snap_err_q;
    assign bus.LOSS_CNT = loss_q;
    assign bus.SAT      = sat_q;
    assign bus.BUSY     = busy_q;

endmodule
